// File: rtl/ddr_serializer_tx_pkg.sv
// Shared definitions for the dual-edge serial link (transmitter and receiver framing checker).
//   state_e             : serializer FSM encodings ST_IDLE / ST_SHIFT
//   WIDTH_DEFAULT       : default bits per word
//   IDLE_LEVEL_DEFAULT  : default line level when nothing is in flight
//   cnt_width()         : pair-counter width for a given word width
package ddr_serializer_tx_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam int unsigned WIDTH_DEFAULT      = 8;
    localparam logic        IDLE_LEVEL_DEFAULT = 1'b0;

    // clog2(width/2), floored at one bit so a 2-bit word still has a legal counter
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width / 2 > 1) ? $clog2(width / 2) : 1;
    endfunction

endpackage

// File: rtl/ddr_serializer_tx_if.sv
// Parallel word handshake into the serializer.
//   in_data  : word to send, sampled on accept
//   in_valid : word present
//   in_ready : serializer can take a word this cycle (combinational from state)
interface ddr_serializer_tx_if #(
    parameter int unsigned WIDTH = 8
) ();

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (output in_data, output in_valid, input  in_ready);
    modport slave  (input  in_data, input  in_valid, output in_ready);

endinterface

// File: rtl/ddr_serializer_tx_launch.sv
// Dual-edge launch pair: a posedge flop and a negedge flop whose XOR is the line.
// Each flop only ever changes on its own edge, so q_o is glitch-free without a clock mux.
//   clk_i, rst_i : clock (both edges used), async active-high reset
//   rise_bit_i   : bit shown during the high phase after the posedge
//   fall_bit_i   : bit shown during the following low phase (must be stable at the negedge)
//   q_o          : serial line, IDLE_LEVEL while in reset
module ddr_serializer_tx_launch
    import ddr_serializer_tx_pkg::*;
#(
    parameter logic IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rise_bit_i,
    input  logic fall_bit_i,
    output logic q_o
);

    logic p_q;
    logic n_q;

    // p^n becomes rise_bit after the posedge
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) p_q <= IDLE_LEVEL;
        else       p_q <= rise_bit_i ^ n_q;
    end

    // p^n becomes fall_bit after the negedge
    always_ff @(negedge clk_i or posedge rst_i) begin
        if (rst_i) n_q <= 1'b0;
        else       n_q <= fall_bit_i ^ p_q;
    end

    assign q_o = p_q ^ n_q;

endmodule

// File: rtl/ddr_serializer_tx.sv
// DDR serializer transmit end: takes a parallel word per valid/ready handshake and sends it
// MSB-first, two bits per clock cycle (first bit in the high phase, second in the low phase).
//   clk_i, rst_i : clock, async active-high reset
//   in_if        : word handshake (slave side)
//   q_o          : DDR serial output
//   q_en_o       : high in every cycle that carries word bits
//   done_o       : one-cycle pulse while the last bit pair of a word is on q_o
module ddr_serializer_tx
    import ddr_serializer_tx_pkg::*;
#(
    parameter int unsigned WIDTH      = WIDTH_DEFAULT,
    parameter logic        IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
    input  logic               clk_i,
    input  logic               rst_i,
    ddr_serializer_tx_if.slave in_if,
    output logic               q_o,
    output logic               q_en_o,
    output logic               done_o
);

    localparam int unsigned     CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH / 2 - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             fall_q, fall_d;
    logic             q_en_q, q_en_d;
    logic             done_q, done_d;
    logic             rise_bit_c;
    logic             last_pair_c;
    logic             ready_c;
    logic             accept_c;

    // State and datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            fall_q  <= IDLE_LEVEL;
            q_en_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            fall_q  <= fall_d;
            q_en_q  <= q_en_d;
            done_q  <= done_d;
        end
    end

    // Next state: cnt_q is the pair launched at the coming posedge, so a word accepted at
    // the edge that launches the last pair follows with no bubble.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        fall_d      = IDLE_LEVEL;
        rise_bit_c  = IDLE_LEVEL;
        q_en_d      = 1'b0;
        done_d      = 1'b0;
        last_pair_c = (state_q == ST_SHIFT) && (cnt_q == LAST_CNT);
        ready_c     = (state_q == ST_IDLE) || last_pair_c;
        accept_c    = in_if.in_valid && ready_c;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    sh_d    = in_if.in_data;
                end
            end
            ST_SHIFT: begin
                rise_bit_c = sh_q[WIDTH-1];
                fall_d     = sh_q[WIDTH-2];
                q_en_d     = 1'b1;
                sh_d       = sh_q << 2;
                if (last_pair_c) begin
                    done_d = 1'b1;
                    cnt_d  = '0;
                    if (accept_c) begin
                        sh_d = in_if.in_data;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_if.in_ready = ready_c && !rst_i;
    assign q_en_o         = q_en_q;
    assign done_o         = done_q;

    ddr_serializer_tx_launch #(
        .IDLE_LEVEL (IDLE_LEVEL)
    ) u_launch (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rise_bit_i (rise_bit_c),
        .fall_bit_i (fall_q),
        .q_o        (q_o)
    );

endmodule
